key_expand_engine: RTL
======================

# key_expand_engine

Iterative, parametrised AES key-schedule engine. It generalises the single-round combinational key step to AES-128/192/256 with one parameter. It generates the full expanded key one 32-bit word per cycle into an internal word store, then serves any round key on request with a registered read port. It sits between the key-load path and the cipher round datapath, so the datapath no longer chains combinational key rounds.

## Interface
- KEY_BITS, 128, cipher key length. Legal values: 128, 192, 256. NK = KEY_BITS/32, NR = NK+6, NW = 4*(NR+1).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  load `key_in` and begin expansion; accepted only in IDLE or READY.
- key_in  in  KEY_BITS  cipher key; `key_in[KEY_BITS-1 -: 32]` is w[0], and the LSB word is w[NK-1].
- busy  out  1  high in EXPAND.
- key_valid  out  1  high in READY (full schedule present).
- done  out  1  one-cycle pulse on entry to READY.
- rk_req  in  1  round-key read request.
- rk_round  in  4  round index, 0..NR.
- rk_valid  out  1  registered response strobe, one cycle after an accepted `rk_req`.
- rk_err  out  1  registered, qualified by `rk_valid`; high when `rk_round` > NR.
- rk_out  out  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]}; 0 when `rk_err` is high.

## Operation
- **State machine:** IDLE, EXPAND, READY. Reset enters IDLE.
- **IDLE/READY to EXPAND, on `start`:**
  - w[0..NK-1] is written from `key_in`.
  - Word counter i is set to NK.
  - rcon is set to 0x01.
- **EXPAND:** each cycle computes and writes w[i], then i increments.
  - temp = w[i-1].
  - If i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, and rcon <= xtime(rcon), where xtime = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
  - Else if NK == 8 and i mod NK == 4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp.
  - RotWord rotates left by one byte.
  - SubWord uses four `sbox_rom_comb` instances, with one word's S-box lookups per cycle.
  - i mod NK is tracked with a separate wrap counter (0..NK-1). No divider.
- **EXPAND to READY:** when i == NW-1 is written.
- **`start` in EXPAND:** ignored, with no restart and no effect.
- **`start` in READY:** re-expands. `key_valid` drops at that edge and the old schedule is overwritten.
- **Reads:**
  - `rk_req` is accepted only when `key_valid` = 1. Otherwise it is ignored, with no `rk_valid`.
  - A read and `start` in the same READY cycle: the read is served from the old w[] contents, since the new key overwrites w[0..NK-1] at the same edge. Reads return the pre-edge store.
- **Reset mid-expansion:** asynchronous return to IDLE. All outputs go to 0. The store contents are don't-care.

## Timing
- **Reset values:** `busy`, `key_valid`, `done`, `rk_valid`, `rk_err` = 0; `rk_out` = 0.
- **`start` at edge E0:** `busy` = 1 from E0.
- **Word writes:** one per edge, E1..E(NW-NK).
- **Last word:** written at edge E(NW-NK). At the same edge `busy` goes to 0, `key_valid` goes to 1 and `done` goes to 1 for exactly one cycle.
- **Expansion length in cycles:** 40 (128), 46 (192), 52 (256).
- **Read latency:** `rk_req` sampled at edge R gives `rk_valid`/`rk_out`/`rk_err` valid after edge R. `rk_valid` is a one-cycle pulse per request.
- **Throughput:** back-to-back requests give one response per cycle.
- **Store size:** NW×32 bits (max 60 words). Counter i is 6 bits; rcon is 8 bits.

## Test plan
- **KEY_BITS=128:** key 2b7e151628aed2a6abf7158809cf4f3c, start.
  - `done` arrives 40 cycles after the start edge.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- **KEY_BITS=192:** key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
  - `done` after 46 cycles.
  - Round 12 = e98ba06f448c773c8ecc720401002202.
- **KEY_BITS=256:** key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
  - `done` after 52 cycles.
  - Round 14 = fe4890d1e6188d0b046df344706c631e, which exercises the i mod 8 == 4 SubWord path.
- **Handshake edges, 128:**
  - `rk_req` during EXPAND gives no `rk_valid`.
  - `start` pulsed mid-EXPAND is ignored, and `done` still arrives at cycle 40.
  - `rk_round` = 11 gives `rk_valid` = 1, `rk_err` = 1, `rk_out` = 0.
  - Back-to-back requests for rounds 0..10 give 11 consecutive `rk_valid` pulses.
- **Reset mid-operation:** assert `rst_n` = 0 at cycle 20 of expansion.
  - All outputs go to 0 immediately, without waiting for `clk`.
  - After release, a new start with the 128-bit key gives correct round 10 after 40 cycles.
- **Re-key from READY, 128:** with `start` and `rk_req` (round 0) in the same cycle:
  - The response is the old round-0 key.
  - `key_valid` is 0 the next cycle.
  - The new schedule's round 0 equals the new `key_in`.

Source files
------------

// File: rtl/key_expand_engine_if.sv
// Key-load and round-key read bundle between the key schedule engine and its user.
// The master side loads keys and issues reads; the slave side is the engine.
interface key_expand_engine_if #(
    parameter int KEY_BITS = 128
);
    logic                start;
    logic [KEY_BITS-1:0] key_in;
    logic                busy;
    logic                key_valid;
    logic                done;
    logic                rk_req;
    logic [3:0]          rk_round;
    logic                rk_valid;
    logic                rk_err;
    logic [127:0]        rk_out;

    modport master (
        output start, key_in, rk_req, rk_round,
        input  busy, key_valid, done, rk_valid, rk_err, rk_out
    );

    modport slave (
        input  start, key_in, rk_req, rk_round,
        output busy, key_valid, done, rk_valid, rk_err, rk_out
    );
endinterface

// File: rtl/key_expand_engine.sv
// Iterative AES-128/192/256 key schedule: expands one 32-bit word per cycle into a
// word store, then serves round keys through a registered read port.

module sbox_rom_comb (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = SBOX[{(8'd255 - in_i), 3'b000} +: 8];
endmodule

module key_expand_engine #(
    parameter int KEY_BITS = 128
) (
    input logic           clk,
    input logic           rst_n,
    key_expand_engine_if.slave bus
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam logic [5:0] NK_W      = 6'(NK);
    localparam logic [5:0] LAST_W    = 6'(NW - 1);
    localparam logic [2:0] WRAP_LAST = 3'(NK - 1);
    localparam logic [3:0] NR_R      = 4'(NR);

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_READY} state_t;

    state_t       state_q, state_d;
    logic [5:0]   idx_q, idx_d;
    logic [2:0]   wrap_q, wrap_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         done_q, done_d;
    logic         rk_valid_q, rk_valid_d;
    logic         rk_err_q, rk_err_d;
    logic [127:0] rk_out_q, rk_out_d;
    logic [31:0]  w_q [NW];

    logic [31:0]  prev_w, old_w, sub_in, sub_out, temp, new_w;
    logic [5:0]   rd_base;
    logic         load_key;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    assign prev_w   = w_q[idx_q - 6'd1];
    assign old_w    = w_q[idx_q - NK_W];
    assign load_key = bus.start && (state_q != S_EXPAND);

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        sbox_rom_comb u_sbox (
            .in_i  (sub_in[8*b +: 8]),
            .out_o (sub_out[8*b +: 8])
        );
    end

    // Word step: RotWord+SubWord+rcon at the start of each key block, bare SubWord
    // mid-block for 256-bit keys.
    always_comb begin
        sub_in = (wrap_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
        temp   = prev_w;
        if (wrap_q == 3'd0)
            temp = sub_out ^ {rcon_q, 24'h0};
        else if (NK == 8 && wrap_q == 3'd4)
            temp = sub_out;
        new_w = old_w ^ temp;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wrap_d  = wrap_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE, S_READY: begin
                if (bus.start) begin
                    state_d = S_EXPAND;
                    idx_d   = NK_W;
                    wrap_d  = 3'd0;
                    rcon_d  = 8'h01;
                end
            end
            S_EXPAND: begin
                idx_d  = idx_q + 6'd1;
                wrap_d = (wrap_q == WRAP_LAST) ? 3'd0 : wrap_q + 3'd1;
                if (wrap_q == 3'd0)
                    rcon_d = xtime(rcon_q);
                if (idx_q == LAST_W) begin
                    state_d = S_READY;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reads see the store as it was before the edge, so a same-cycle re-key returns the old key.
    always_comb begin
        rd_base    = {bus.rk_round, 2'b00};
        rk_valid_d = bus.rk_req && (state_q == S_READY);
        rk_err_d   = rk_err_q;
        rk_out_d   = rk_out_q;
        if (rk_valid_d) begin
            rk_err_d = (bus.rk_round > NR_R);
            rk_out_d = rk_err_d ? 128'h0 :
                       {w_q[rd_base], w_q[rd_base + 6'd1],
                        w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 6'd0;
            wrap_q     <= 3'd0;
            rcon_q     <= 8'h00;
            done_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_err_q   <= 1'b0;
            rk_out_q   <= 128'h0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wrap_q     <= wrap_d;
            rcon_q     <= rcon_d;
            done_q     <= done_d;
            rk_valid_q <= rk_valid_d;
            rk_err_q   <= rk_err_d;
            rk_out_q   <= rk_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_key) begin
            for (int k = 0; k < NK; k++)
                w_q[k] <= bus.key_in[KEY_BITS-1-32*k -: 32];
        end else if (state_q == S_EXPAND) begin
            w_q[idx_q] <= new_w;
        end
    end

    assign bus.busy      = (state_q == S_EXPAND);
    assign bus.key_valid = (state_q == S_READY);
    assign bus.done      = done_q;
    assign bus.rk_valid  = rk_valid_q;
    assign bus.rk_err    = rk_err_q;
    assign bus.rk_out    = rk_out_q;
endmodule
